instr_mem_loader: RTL and testbench

Boot-time writer for the instruction memory. It is the write-side counterpart of the fetch path, which only ever reads that memory. It accepts a byte stream over a valid/ready handshake, packs bytes into little-endian 32-bit instruction words, and drives the instruction memory write port at sequential word addresses. While loading it holds the fetch stage frozen so that no instruction is fetched from a partially written image.

---
 rtl/instr_mem_loader_pkg.sv | 24 ++
 rtl/instr_mem_loader_byte_packer.sv | 27 ++
 rtl/instr_mem_loader.sv | 108 ++++++++++
 tb/tb_instr_mem_loader.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/instr_mem_loader_pkg.sv
// Shared widths and helpers for the instruction-memory boot loader.
// The width macros are guarded so that an existing Defines.v already in the compile takes precedence.
`ifndef ADDRESS_LEN
`define ADDRESS_LEN 32
`endif
`ifndef INSTRUCTION_LEN
`define INSTRUCTION_LEN 32
`endif
`ifndef LOADER_LEN_BITS
`define LOADER_LEN_BITS 16
`endif

package instr_mem_loader_pkg;
  localparam int LEN_BITS   = `LOADER_LEN_BITS;
  localparam int STATE_BITS = 3;

  typedef logic [`INSTRUCTION_LEN-1:0] instr_t;
  typedef logic [`ADDRESS_LEN-1:0]     addr_t;

  // Byte address of word idx; wraps at the address width.
  function automatic addr_t word_addr(input addr_t base, input addr_t idx);
    return base + (idx << 2);
  endfunction
endpackage

// File: rtl/instr_mem_loader_byte_packer.sv
// Packs a byte stream into little-endian 32-bit words: the first byte lands in [7:0].
module instr_mem_loader_byte_packer
  import instr_mem_loader_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       shift_en,
  input  logic       clear,
  input  logic [7:0] byte_in,
  output instr_t     word,
  output logic       word_complete
);
  logic [1:0] count;

  // Asserted while the fourth byte of a word is being shifted in.
  assign word_complete = shift_en && (count == 2'd3);

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      word  <= '0;
      count <= '0;
    end else if (shift_en) begin
      word  <= {byte_in, word[`INSTRUCTION_LEN-1:8]};
      count <= count + 2'd1;
    end
  end
endmodule

// File: rtl/instr_mem_loader.sv
// Boot-time writer for the instruction memory: length-prefixed byte stream in,
// sequential word writes out, fetch held frozen for the duration of the load.
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int    MEM_WORDS = 1024,
  parameter addr_t BASE_ADDR = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        in_valid,
  input  logic [7:0]                  in_data,
  output logic                        in_ready,
  output logic                        mem_write_en,
  output logic [`ADDRESS_LEN-1:0]     mem_address,
  output logic [`INSTRUCTION_LEN-1:0] mem_write_data,
  output logic                        freeze,
  output logic                        done,
  output logic                        error,
  output logic [STATE_BITS-1:0]       dbg_state
);
  localparam int IDX_W = $clog2(MEM_WORDS + 1);
  localparam logic [31:0] MAX_WORDS = 32'(MEM_WORDS);

  localparam logic [STATE_BITS-1:0] S_IDLE   = 3'd0;
  localparam logic [STATE_BITS-1:0] S_LEN_LO = 3'd1;
  localparam logic [STATE_BITS-1:0] S_LEN_HI = 3'd2;
  localparam logic [STATE_BITS-1:0] S_DATA   = 3'd3;
  localparam logic [STATE_BITS-1:0] S_WRITE  = 3'd4;
  localparam logic [STATE_BITS-1:0] S_DONE   = 3'd5;
  localparam logic [STATE_BITS-1:0] S_ERROR  = 3'd6;

  logic [STATE_BITS-1:0] state;
  logic [LEN_BITS-1:0]   len;
  logic [LEN_BITS-1:0]   len_full;
  logic [IDX_W-1:0]      idx;
  logic                  start_ok;
  logic                  shift_en;
  logic                  word_complete;
  instr_t                packed_word;

  // Handshake: a byte moves on a rising edge where in_valid and in_ready are both high.
  // in_ready decodes the registered state only, so it never depends on in_valid.
  assign in_ready = (state == S_LEN_LO) || (state == S_LEN_HI) || (state == S_DATA);
  assign start_ok = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERROR));
  assign shift_en = in_valid && (state == S_DATA);
  assign len_full = {in_data, len[7:0]};

  instr_mem_loader_byte_packer u_byte_packer (
    .clk           (clk),
    .rst           (rst),
    .shift_en      (shift_en),
    .clear         (start_ok),
    .byte_in       (in_data),
    .word          (packed_word),
    .word_complete (word_complete)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
      len   <= '0;
      idx   <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            state <= S_LEN_LO;
            len   <= '0;
            idx   <= '0;
          end
        end
        S_LEN_LO: begin
          if (in_valid) begin
            len[7:0] <= in_data;
            state    <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (in_valid) begin
            len[15:8] <= in_data;
            if (len_full == '0)                     state <= S_DONE;
            else if (32'(len_full) > MAX_WORDS)     state <= S_ERROR;
            else                                    state <= S_DATA;
          end
        end
        S_DATA: begin
          if (word_complete) state <= S_WRITE;
        end
        S_WRITE: begin
          idx <= idx + IDX_W'(1);
          if (32'(idx) + 32'd1 == 32'(len)) state <= S_DONE;
          else                               state <= S_DATA;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign mem_write_en   = (state == S_WRITE);
  assign mem_address    = mem_write_en ? word_addr(BASE_ADDR, addr_t'(idx)) : '0;
  assign mem_write_data = mem_write_en ? packed_word : '0;
  assign freeze         = in_ready || (state == S_WRITE) || (state == S_ERROR);
  assign done           = (state == S_DONE);
  assign error          = (state == S_ERROR);
  assign dbg_state      = state;
endmodule

// File: tb/tb_instr_mem_loader.sv
// Bench for instr_mem_loader: dut 0 has MEM_WORDS=4 at base 0, dut 1 has MEM_WORDS=1024 at base 0x100.
module tb_instr_mem_loader;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst_v      = '0;
  logic [1:0]       start_v    = '0;
  logic [1:0]       in_valid_v = '0;
  logic [1:0][7:0]  in_data_v  = '0;
  logic [1:0]       in_ready_v, wen_v, freeze_v, done_v, error_v;
  logic [1:0][31:0] addr_v, data_v;
  logic [1:0][2:0]  state_v;

  logic [31:0] base_c [2] = '{32'h0, 32'h100};
  logic [63:0] exp_q0[$];
  logic [63:0] exp_q1[$];
  logic [31:0] wbuf[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int t0 [2] = '{0, 0};

  always @(posedge clk) cyc <= cyc + 1;

  instr_mem_loader #(.MEM_WORDS(4), .BASE_ADDR(32'h0)) dut0 (
    .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .in_valid(in_valid_v[0]),
    .in_data(in_data_v[0]), .in_ready(in_ready_v[0]), .mem_write_en(wen_v[0]),
    .mem_address(addr_v[0]), .mem_write_data(data_v[0]), .freeze(freeze_v[0]),
    .done(done_v[0]), .error(error_v[0]), .dbg_state(state_v[0])
  );

  instr_mem_loader #(.MEM_WORDS(1024), .BASE_ADDR(32'h100)) dut1 (
    .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .in_valid(in_valid_v[1]),
    .in_data(in_data_v[1]), .in_ready(in_ready_v[1]), .mem_write_en(wen_v[1]),
    .mem_address(addr_v[1]), .mem_write_data(data_v[1]), .freeze(freeze_v[1]),
    .done(done_v[1]), .error(error_v[1]), .dbg_state(state_v[1])
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input int d, input logic [31:0] a, input logic [31:0] w);
    if (d == 0) exp_q0.push_back({a, w});
    else        exp_q1.push_back({a, w});
  endtask

  // Scoreboard: every write strobe pops one expected {address, data}.
  always @(negedge clk) begin
    if (wen_v[0]) begin
      check_eq("write_expected0", 64'(exp_q0.size() != 0), 64'd1);
      if (exp_q0.size() != 0) check_eq("write0", {addr_v[0], data_v[0]}, exp_q0.pop_front());
    end else begin
      check_eq("idle_bus0", {addr_v[0], data_v[0]}, 64'd0);
    end
    if (wen_v[1]) begin
      check_eq("write_expected1", 64'(exp_q1.size() != 0), 64'd1);
      if (exp_q1.size() != 0) check_eq("write1", {addr_v[1], data_v[1]}, exp_q1.pop_front());
    end else begin
      check_eq("idle_bus1", {addr_v[1], data_v[1]}, 64'd0);
    end
  end

  task automatic pulse_start(input int d);
    @(negedge clk);
    start_v[d] = 1'b1;
    in_valid_v[d] = 1'b0;
    @(posedge clk);
    #1;
    start_v[d] = 1'b0;
    t0[d] = cyc;
    check_eq("start_accept", {62'd0, in_ready_v[d], freeze_v[d]} << 2 | {62'd0, done_v[d], error_v[d]},
             64'b1100);
  endtask

  task automatic send_byte(input int d, input logic [7:0] b, input bit st);
    bit acc = 1'b0;
    int n = 0;
    while (!acc) begin
      @(negedge clk);
      in_valid_v[d] = 1'b1;
      in_data_v[d]  = b;
      start_v[d]    = st;
      acc = in_ready_v[d];
      @(posedge clk);
      n++;
      if (!acc && n > 50) begin
        check_eq("send_timeout", 64'(n), 64'd0);
        acc = 1'b1;
      end
    end
    #1 start_v[d] = 1'b0;
  endtask

  task automatic gap(input int d);
    @(negedge clk);
    in_valid_v[d] = 1'b0;
    @(posedge clk);
  endtask

  task automatic wait_done(input int d, output int lat);
    int n = 0;
    @(negedge clk);
    in_valid_v[d] = 1'b0;
    while (!done_v[d] && !error_v[d] && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) check_eq("done_timeout", 64'(n), 64'd0);
    lat = cyc - t0[d];
  endtask

  // bub: 0 continuous, 1 a gap before every byte, 2 random gaps.
  task automatic load(input int d, input int n, input int bub, input bit mid_start);
    logic [15:0] len;
    logic [31:0] w;
    len = 16'(n);
    for (int i = 0; i < n; i++) push_exp(d, base_c[d] + 32'(4 * i), wbuf[i]);
    pulse_start(d);
    send_byte(d, len[7:0], 1'b0);
    send_byte(d, len[15:8], 1'b0);
    for (int i = 0; i < n; i++) begin
      w = wbuf[i];
      for (int k = 0; k < 4; k++) begin
        if (bub == 1 || (bub == 2 && $urandom_range(0, 1) == 1)) gap(d);
        send_byte(d, w[8*k +: 8], mid_start && i == 0 && k == 2);
      end
    end
  endtask

  function automatic logic [63:0] flags(input int d);
    return {60'd0, done_v[d], error_v[d], freeze_v[d], in_ready_v[d]};
  endfunction

  initial begin
    int lat;
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset_flags0", flags(0) | {state_v[0], 4'd0}, 64'd0);
    check_eq("reset_flags1", flags(1) | {state_v[1], 4'd0}, 64'd0);
    rst_v = 2'b11;

    // Reset in the middle of a word: nothing written, partial word discarded.
    pulse_start(0);
    send_byte(0, 8'h02, 1'b0);
    send_byte(0, 8'h00, 1'b0);
    send_byte(0, 8'h55, 1'b0);
    send_byte(0, 8'h66, 1'b0);
    @(negedge clk);
    in_valid_v[0] = 1'b0;
    check_eq("data_flags", flags(0), 64'b0011);
    rst_v[0] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("midload_reset", flags(0) | {state_v[0], 4'd0} | {wen_v[0], 7'd0}, 64'd0);
    rst_v[0] = 1'b1;

    // Nominal two-word load.
    wbuf = '{32'h04030201, 32'hDDCCBBAA};
    load(0, 2, 0, 1'b0);
    wait_done(0, lat);
    check_eq("nominal_latency", 64'(lat), 64'd12);
    check_eq("nominal_flags", flags(0), 64'b1000);

    // Zero length.
    pulse_start(0);
    send_byte(0, 8'h00, 1'b0);
    send_byte(0, 8'h00, 1'b0);
    wait_done(0, lat);
    check_eq("zero_latency", 64'(lat), 64'd2);
    check_eq("zero_flags", flags(0), 64'b1000);

    // Oversize, then recovery.
    pulse_start(0);
    send_byte(0, 8'h05, 1'b0);
    send_byte(0, 8'h00, 1'b0);
    wait_done(0, lat);
    check_eq("oversize_flags", flags(0), 64'b0110);
    repeat (3) @(negedge clk);
    check_eq("error_sticky", flags(0), 64'b0110);
    wbuf = '{32'h44332211};
    load(0, 1, 0, 1'b0);
    wait_done(0, lat);
    check_eq("recover_flags", flags(0), 64'b1000);

    // Exactly MEM_WORDS is accepted.
    wbuf = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    load(0, 4, 0, 1'b0);
    wait_done(0, lat);
    check_eq("full_flags", flags(0), 64'b1000);
    check_eq("full_latency", 64'(lat), 64'd22);

    // Bubbles with a start pulse inside DATA.
    wbuf = '{32'h04030201, 32'hDDCCBBAA};
    load(0, 2, 1, 1'b1);
    wait_done(0, lat);
    check_eq("bubble_flags", flags(0), 64'b1000);

    // Offset base, three words, then random loads.
    wbuf = '{32'hCAFE0001, 32'hCAFE0002, 32'hCAFE0003};
    load(1, 3, 0, 1'b0);
    wait_done(1, lat);
    check_eq("base_latency", 64'(lat), 64'd17);
    check_eq("base_flags", flags(1), 64'b1000);
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, 5);
      wbuf.delete();
      for (int i = 0; i < n; i++) wbuf.push_back($urandom);
      load(1, n, 2, 1'b0);
      wait_done(1, lat);
      check_eq("rand_flags", flags(1), 64'b1000);
    end

    repeat (6) @(negedge clk);
    check_eq("leftover0", 64'(exp_q0.size()), 64'd0);
    check_eq("leftover1", 64'(exp_q1.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    check_eq("watchdog", 64'd1, 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
